am_insert_tx: RTL and testbench

- Transmit-side alignment marker inserter for the multi-lane 40GBASE-R PCS.
- Sits after the per-lane block distribution and before the scrambler-bypass/gearbox path.
- Every GAP_N data blocks it replaces one output slot, on all lanes simultaneously, with the lane's alignment marker, including the BIP3/BIP7 parity.
- This is the stream the RX alignment-marker lock block searches for.
- The upstream source is back-pressured for one cycle per marker.

---
 rtl/am_insert_tx.sv | 72 +++++++
 tb/tb_am_insert_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/am_insert_tx.sv
// am_insert_tx: inserts per-lane 40GBASE-R alignment markers with BIP3/BIP7 every GAP_N data blocks
module am_insert_tx #(
  parameter int BLOCK_W = 66,
  parameter int LANE_N  = 4,
  parameter int GAP_N   = 16383
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [LANE_N*BLOCK_W-1:0]   block_i,
  output logic                        valid_o,
  output logic [LANE_N*BLOCK_W-1:0]   block_o,
  output logic                        am_o
);
  localparam int CW = $clog2(GAP_N + 1);
  localparam logic [CW-1:0] GAP_C = CW'(GAP_N);
  localparam logic [95:0] AM_TAB = {24'ha2793d, 24'hc5659b, 24'hf0c4e6, 24'h907647};
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [LANE_N*8-1:0]        bip_q, bip_d;
  logic                       valid_q, valid_d, am_q, am_d;
  logic [LANE_N*BLOCK_W-1:0]  block_q, block_d, out;
  logic                       mark, take;
  function automatic logic [7:0] fold(input logic [BLOCK_W-1:0] b);
    logic [7:0] x;
    x = {3'b0, b[1], b[0], 3'b0};
    for (int k = 0; k < 8; k++) x = x ^ b[8*k+2 +: 8];
    return x;
  endfunction
  function automatic logic [BLOCK_W-1:0] am_blk(input int l, input logic [7:0] p);
    logic [23:0] m;
    m = AM_TAB[(l % 4)*24 +: 24];
    return {~p, ~m[7:0], ~m[15:8], ~m[23:16], p, m[7:0], m[15:8], m[23:16], 2'b10};
  endfunction
  assign ready_o = !reset && !mark;
  assign valid_o = valid_q;
  assign am_o    = am_q;
  assign block_o = block_q;
  // slot decision: marker when cnt is 0, otherwise forward an offered block
  always_comb begin
    mark    = cnt_q == '0;
    take    = !mark && valid_i;
    cnt_d   = mark ? CW'(1) : !take ? cnt_q : cnt_q == GAP_C ? '0 : cnt_q + CW'(1);
    out     = block_i;
    bip_d   = bip_q;
    for (int l = 0; l < LANE_N; l++) begin
      if (mark) out[l*BLOCK_W +: BLOCK_W] = am_blk(l, bip_q[l*8 +: 8]);
      bip_d[l*8 +: 8] = mark ? fold(am_blk(l, bip_q[l*8 +: 8])) :
                        take ? bip_q[l*8 +: 8] ^ fold(block_i[l*BLOCK_W +: BLOCK_W]) :
                        bip_q[l*8 +: 8];
    end
    valid_d = mark || take;
    am_d    = mark;
    block_d = valid_d ? out : block_q;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      bip_q   <= '0;
      valid_q <= 1'b0;
      am_q    <= 1'b0;
      block_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      bip_q   <= bip_d;
      valid_q <= valid_d;
      am_q    <= am_d;
      block_q <= block_d;
    end
  end
endmodule

// File: tb/tb_am_insert_tx.sv
// tb_am_insert_tx: directed checks of marker insertion, BIP and flow control
module tb_am_insert_tx;
  localparam int W = 66, L = 4, D = L*W;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic r4, v4, rd4, vo4, am4, r2, v2, rd2, vo2, am2;
  logic [D-1:0] b4, bo4, b2, bo2, last;
  logic [31:0] acc;
  logic vs [7];
  int nchk = 0, nerr = 0, cur;
  logic [23:0] amt [4];
  am_insert_tx #(.GAP_N(4)) dut4 (.clk(clk), .reset(r4), .valid_i(v4), .ready_o(rd4), .block_i(b4),
    .valid_o(vo4), .block_o(bo4), .am_o(am4));
  am_insert_tx #(.GAP_N(2)) dut2 (.clk(clk), .reset(r2), .valid_i(v2), .ready_o(rd2), .block_i(b2),
    .valid_o(vo2), .block_o(bo2), .am_o(am2));
  task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] fold(input logic [W-1:0] b);
    logic [7:0] x;
    x = 8'h0;
    for (int k = 0; k < 8; k++) x ^= b[8*k+2 +: 8];
    if (b[0]) x ^= 8'h08;
    if (b[1]) x ^= 8'h10;
    return x;
  endfunction
  function automatic logic [31:0] foldall(input logic [D-1:0] b);
    logic [31:0] r;
    for (int l = 0; l < L; l++) r[l*8 +: 8] = fold(b[l*W +: W]);
    return r;
  endfunction
  function automatic logic [D-1:0] mkall(input logic [31:0] p);
    logic [D-1:0] r;
    logic [23:0] m;
    logic [7:0] q;
    for (int l = 0; l < L; l++) begin
      m = amt[l];
      q = p[l*8 +: 8];
      r[l*W +: W] = {~q, ~m[7:0], ~m[15:8], ~m[23:16], q, m[7:0], m[15:8], m[23:16], 2'b10};
    end
    return r;
  endfunction
  function automatic logic [D-1:0] dat(input int i);
    logic [D-1:0] r;
    for (int l = 0; l < L; l++)
      r[l*W +: W] = {32'(i*32'h11111111), 24'(l*24'h010203), 8'(i+l), (i % 2 == 1) ? 2'b01 : 2'b10};
    return r;
  endfunction
  initial begin
    amt = '{24'h907647, 24'hf0c4e6, 24'hc5659b, 24'ha2793d};
    vs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    r4 = 1'b1; v4 = 1'b0; b4 = '0;
    r2 = 1'b1; v2 = 1'b0; b2 = '0;
    tick();
    tick();
    chk("rst_ready", D'(rd4), D'(0));
    chk("rst_valid", D'(vo4), D'(0));
    chk("rst_am", D'(am4), D'(0));
    chk("rst_block", bo4, '0);
    r4 = 1'b0; v4 = 1'b1; b4 = '0;
    #1;
    chk("mk1_slot_ready", D'(rd4), D'(0));
    tick();
    chk("mk1_flags", D'({vo4, am4}), D'(2'b11));
    chk("mk1_lane0", D'(bo4[65:0]), D'({8'hff, 8'hb8, 8'h89, 8'h6f, 8'h00, 8'h47, 8'h76, 8'h90, 2'b10}));
    chk("mk1_all", bo4, mkall(32'h0));
    acc = {4{8'h10}};
    for (int i = 1; i <= 4; i++) begin
      b4 = dat(i);
      #1;
      chk("p1_ready", D'(rd4), D'(1));
      tick();
      chk("p1_flags", D'({vo4, am4}), D'(2'b10));
      chk("p1_block", bo4, dat(i));
      acc ^= foldall(dat(i));
    end
    b4 = dat(5);
    #1;
    chk("mk2_slot_ready", D'(rd4), D'(0));
    tick();
    chk("mk2_flags", D'({vo4, am4}), D'(2'b11));
    chk("mk2_block", bo4, mkall(acc));
    last = mkall(acc);
    acc = {4{8'h10}};
    cur = 5;
    for (int k = 0; k < 7; k++) begin
      v4 = vs[k];
      b4 = vs[k] ? dat(cur) : ~dat(cur);
      tick();
      if (vs[k]) begin
        chk("gap_flags", D'({vo4, am4}), D'(2'b10));
        chk("gap_block", bo4, dat(cur));
        acc ^= foldall(dat(cur));
        last = dat(cur);
        cur++;
      end else begin
        chk("idle_flags", D'({vo4, am4}), D'(2'b00));
        chk("idle_hold", bo4, last);
      end
    end
    v4 = 1'b1; b4 = dat(9);
    #1;
    chk("mk3_slot_ready", D'(rd4), D'(0));
    tick();
    chk("mk3_block", bo4, mkall(acc));
    chk("mk3_flags", D'({vo4, am4}), D'(2'b11));
    tick();
    chk("mid_blk9", bo4, dat(9));
    b4 = dat(10);
    tick();
    chk("mid_blk10", bo4, dat(10));
    r4 = 1'b1; b4 = dat(11);
    #1;
    chk("mid_rst_ready", D'(rd4), D'(0));
    tick();
    chk("mid_rst_flags", D'({vo4, am4}), D'(2'b00));
    chk("mid_rst_block", bo4, '0);
    r4 = 1'b0;
    #1;
    chk("mid_rel_ready", D'(rd4), D'(0));
    tick();
    chk("mid_mk_flags", D'({vo4, am4}), D'(2'b11));
    chk("mid_mk_block", bo4, mkall(32'h0));
    acc = {4{8'h10}};
    for (int i = 11; i <= 14; i++) begin
      b4 = dat(i);
      tick();
      chk("mid_block", bo4, dat(i));
      acc ^= foldall(dat(i));
    end
    #1;
    chk("mid_end_ready", D'(rd4), D'(0));
    tick();
    chk("mid_mk2_block", bo4, mkall(acc));
    chk("mid_mk2_flags", D'({vo4, am4}), D'(2'b11));
    r2 = 1'b0; v2 = 1'b0;
    tick();
    chk("g2_mk1_flags", D'({vo2, am2}), D'(2'b11));
    chk("g2_mk1_block", bo2, mkall(32'h0));
    v2 = 1'b1; b2 = {4{66'h1}};
    tick();
    tick();
    chk("g2_data_flags", D'({vo2, am2}), D'(2'b10));
    #1;
    chk("g2_slot_ready", D'(rd2), D'(0));
    tick();
    chk("g2_mk2_flags", D'({vo2, am2}), D'(2'b11));
    for (int l = 0; l < L; l++) chk("g2_cancel_bip", D'({bo2[l*W+26 +: 8], bo2[l*W+58 +: 8]}), D'(16'h10ef));
    b2 = {4{66'h1}};
    tick();
    b2 = {4{66'h2}};
    tick();
    chk("g2_head10_block", bo2, {4{66'h2}});
    v2 = 1'b0;
    tick();
    chk("g2_mk3_flags", D'({vo2, am2}), D'(2'b11));
    for (int l = 0; l < L; l++) chk("g2_mixed_bip", D'({bo2[l*W+26 +: 8], bo2[l*W+58 +: 8]}), D'(16'h08f7));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
